uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter, 8N1 by default. Takes bytes from a TX FIFO and serialises them LSB first on tx.
//  Bit timing comes from the shared 16x-oversampling s_tick, produced by mod_m_counter (same tick as uart_rx).
//  Sits between the host-side TX FIFO and the board TX pin; forms the link partner of uart_rx.
// PARAMETERS
//  DBIT        8    data bits per frame
//  SB_TICK     16   s_ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
//  PARITY_ODD  0    parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise
// PORTS
//  clk            in   1     system clock
//  reset          in   1     synchronous, active-high reset
//  s_tick         in   1     one-clk pulse, 16 per bit period
//  tx_fifo_empty  in   1     TX FIFO empty flag
//  tx_din         in   DBIT  FIFO head word (first-word-fall-through)
//  tx_fifo_rd     out  1     one-clk pop strobe to TX FIFO
//  tx_busy        out  1     high while a frame is in flight
//  tx             out  1     serial line, idle high, registered
// BEHAVIOUR
//  Reset
//   - state = IDLE, tx = 1, tx_busy = 0, tx_fifo_rd = 0; tick counter and bit counter = 0.
//   - Reset mid-frame aborts the frame; tx returns high on the next clk. No FIFO pop is issued.
//  State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: load condition is s_tick & !tx_fifo_empty. On that cycle:
//      - assert tx_fifo_rd for exactly 1 clk;
//      - latch tx_din into the shift register;
//      - set tick_cnt = 0 and go to START.
//     The frame therefore starts on a tick boundary.
//   - Each bit state holds tx for 16 s_ticks. tick_cnt increments on s_tick; on the s_tick where tick_cnt == 15, advance.
//   - START: tx = 0.
//   - DATA: tx = shreg[0]. Shift right at each bit end. bit_cnt runs 0..DBIT-1; exit after bit DBIT-1.
//   - STOP: tx = 1 for SB_TICK ticks, then go to IDLE with tx_busy = 0.
//  Outputs and timing
//   - tx, tx_busy and tx_fifo_rd are all registered. tx falls 1 clk after the tx_fifo_rd cycle.
//   - tx_busy rises together with that tx fall and drops on the clk after the final stop tick.
//   - Frame length = (1 + DBIT + SB_TICK/16 [+1 parity]) bit periods exactly.
//   - Back-to-back frames: the next byte loads on the first s_tick seen in IDLE, giving a 1-tick idle gap.
//  Boundary conditions
//   - Empty FIFO: stays in IDLE, tx = 1, no pop.
//   - FIFO goes non-empty mid-frame: ignored until IDLE.
//   - s_tick is ignored while reset is high.
//   - tx_din may change after the pop cycle with no effect on the current frame.
//   - s_tick stuck low: the FSM holds its current state indefinitely (no timeout).
// CONFIGURATION
//  UART_TX_PARITY_EN
//   - Defined: insert a PARITY state after DATA. It lasts 16 ticks with tx = ^data ^ PARITY_ODD.
//     Parity is computed from the latched byte at load time.
//   - Undefined: DATA goes directly to STOP; no parity logic is synthesised and PARITY_ODD is unused.
// STRUCTURE
//  - uart_defs.vh (shared with uart_rx): state encodings ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP, and OVERSAMPLE = 16.
//  - Single flat module: FSM, 4-bit tick counter, 3-bit bit counter, DBIT shift register. No sub-module.
// TESTING
//  Bench setup: clk period 2 ns; mod_m_counter M = 27 (tick every 54 ns, bit = 864 ns); loopback tx -> uart_rx.rx.
//  1. Reset with tx_fifo_empty = 1 for 5 us -> tx stays 1, tx_fifo_rd never pulses, tx_busy = 0.
//  2. One byte 0xA5 -> single tx_fifo_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 at 864 ns per bit;
//     uart_rx delivers rx_dout = 0xA5.
//  3. Three bytes 0x00, 0xFF, 0x3C back to back -> 3 pops; each gap between frames is 54 ns;
//     rx receives all 3 in order.
//  4. Assert reset 2 us into the 0xA5 frame -> tx = 1 and tx_busy = 0 on the next clk.
//     A following byte 0x5A then transmits cleanly.
//  5. FIFO goes non-empty during the stop bit of the previous frame -> no pop until IDLE and the first s_tick there.
//  6. With UART_TX_PARITY_EN, PARITY_ODD = 0, byte 0x07 -> parity bit = 1.
//     Same run with PARITY_ODD = 1 -> parity bit = 0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// oversampling ratio and a helper that sizes the tick counter.
package uart_tx_pkg;

  // s_ticks per bit period (16x oversampling, same tick as uart_rx)
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // The tick counter must cover a full bit (16) and a long stop bit (up to 32).
  function automatic int tick_cnt_width(input int sb_tick);
    int w;
    w = $clog2(OVERSAMPLE);
    if ($clog2(sb_tick) > w) w = $clog2(sb_tick);
    return w;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Serial UART transmitter, 8N1 by default. Pops bytes from a
// first-word-fall-through TX FIFO and shifts them out LSB first, one bit
// per 16 s_ticks. tx, tx_busy and tx_fifo_rd are all registered.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the
// data bits (sense selected by PARITY_ODD).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT       = 8,   // data bits per frame
  parameter int SB_TICK    = 16,  // s_ticks in the stop bit (16/24/32)
  parameter int PARITY_ODD = 0    // 0 = even, 1 = odd (parity builds only)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_fifo_empty,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx_fifo_rd,
  output logic            tx_busy,
  output logic            tx
);

  localparam int TICK_W = tick_cnt_width(SB_TICK);
  localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DBIT - 1);

  // Reject configurations the frame logic cannot represent.
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end
  if (SB_TICK < 1 || SB_TICK > 32) begin : g_bad_sb_tick
    $error("uart_tx: SB_TICK must be in 1..32");
  end

  tx_state_e         state, state_next;
  logic [TICK_W-1:0] tick_cnt, tick_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [DBIT-1:0]   shreg, shreg_next;
  logic              tx_next, busy_next, rd_next;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit, parity_next;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      // NOTE: the shift register is small, so it is reset along with the
      // control state; this keeps every flop deterministic out of reset.
      shreg      <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_fifo_rd <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state      <= state_next;
      tick_cnt   <= tick_next;
      bit_cnt    <= bit_next;
      shreg      <= shreg_next;
      tx         <= tx_next;
      tx_busy    <= busy_next;
      tx_fifo_rd <= rd_next;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    tick_next   = tick_cnt;
    bit_next    = bit_cnt;
    shreg_next  = shreg;
    tx_next     = 1'b1;
    busy_next   = (state != ST_IDLE);
    rd_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_bit;
`endif

    unique case (state)
      ST_IDLE: begin
        // Load only on a tick so the frame starts on a tick boundary.
        if (s_tick && !tx_fifo_empty) begin
          rd_next     = 1'b1;
          shreg_next  = tx_din;
          tick_next   = '0;
          bit_next    = '0;
`ifdef UART_TX_PARITY_EN
          parity_next = (^tx_din) ^ (PARITY_ODD != 0);
`endif
          state_next  = ST_START;
        end
      end

      ST_START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = ST_DATA;
          end else begin
            tick_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      ST_DATA: begin
        tx_next = shreg[0];
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_next  = '0;
            shreg_next = shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              bit_next = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_next = tick_cnt + TICK_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_next = parity_bit;
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_next  = '0;
            state_next = ST_STOP;
          end else begin
            tick_next = tick_cnt + TICK_W'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (tick_cnt == STOP_LAST) begin
            // Drop busy on the clock right after the final stop tick.
            tick_next  = '0;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            tick_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A single stepping task drives s_tick
// (one pulse every 27 clocks), models the FWFT TX FIFO, and decodes tx with
// a tick-based receiver; bytes popped from the FIFO go to a scoreboard queue
// and are compared when the receiver completes a frame.
module tb_uart_tx;

  parameter int PARITY_ODD = 0;

  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int TICK_DIV = 27;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS       = 1 + DBIT + PAR + 1;  // samples incl. stop
  localparam int FRAME_TICKS = 16 * (1 + DBIT + PAR) + SB_TICK;
  localparam int BUSY_CLKS   = FRAME_TICKS * TICK_DIV - 1;
  localparam int GAP_CLKS    = (FRAME_TICKS + 1) * TICK_DIV;
  localparam int FRAME_BUDGET = (FRAME_TICKS + 40) * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_fifo_empty = 1'b1;
  logic [7:0] tx_din = 8'h00;
  logic       tx_fifo_rd, tx_busy, tx;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(PARITY_ODD)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_tick        (s_tick),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_din        (tx_din),
    .tx_fifo_rd    (tx_fifo_rd),
    .tx_busy       (tx_busy),
    .tx            (tx)
  );

  always #1 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         tick_div = 0;
  bit         tick_en = 1'b1;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         fall_q[$];
  int         pop_cnt = 0;
  int         rd_cyc = -100;
  logic       prev_rd = 1'b0;
  logic       prev_tx = 1'b1;
  logic       prev_busy = 1'b0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  bit         tx_low_seen = 1'b0;
  bit         busy_seen = 1'b0;
  bit         rx_active = 1'b0;
  int         rx_ticks = 0;
  int         rx_idx = 0;
  logic       rx_bits[NBITS];
  int         frame_cnt = 0;
  logic [7:0] last_rx_byte = 8'h00;
  logic       last_rx_par = 1'b0;

  // Compare a decoded frame against the oldest popped byte.
  task automatic check_frame();
    logic [NBITS-1:0] got, want;
    logic [7:0] exp_b;
    for (int i = 0; i < NBITS; i++) got[i] = rx_bits[i];
    for (int i = 0; i < DBIT; i++) last_rx_byte[i] = rx_bits[1+i];
    last_rx_par = rx_bits[1+DBIT];
    frame_cnt++;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL frame_unexpected: got frame %b, want no frame", got);
    end else begin
      exp_b = exp_q.pop_front();
      want = '0;
      want[NBITS-1] = 1'b1;
      for (int i = 0; i < DBIT; i++) want[1+i] = exp_b[i];
`ifdef UART_TX_PARITY_EN
      want[1+DBIT] = (^exp_b) ^ (PARITY_ODD != 0);
`endif
      if (got !== want) begin
        tests_failed++;
        $display("FAIL frame_bits: got %b, want %b", got, want);
      end
    end
  endtask

  // One clock: sample outputs at negedge, update models, drive inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tx_fifo_rd === 1'b1) begin
      tests_run++;
      if (prev_rd === 1'b1 || tx_busy !== 1'b0 || fifo_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rd_pulse: got prev_rd=%b busy=%b fifo=%0d, want 0 0 >0",
                 prev_rd, tx_busy, fifo_q.size());
      end
      if (fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
      pop_cnt++;
      rd_cyc = cyc;
    end
    prev_rd = tx_fifo_rd;

    if (tx_busy === 1'b1) begin
      busy_run++;
      busy_seen = 1'b1;
    end else if (prev_busy === 1'b1) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    prev_busy = tx_busy;
    if (tx !== 1'b1) tx_low_seen = 1'b1;

    if (!rx_active && prev_tx === 1'b1 && tx === 1'b0) begin
      rx_active = 1'b1;
      rx_ticks = 0;
      rx_idx = 0;
      fall_q.push_back(cyc);
      tests_run++;
      if (cyc - rd_cyc != 1 || tx_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_fall_timing: got rd->fall=%0d busy=%b, want 1 1",
                 cyc - rd_cyc, tx_busy);
      end
    end else if (rx_active && s_tick) begin
      rx_ticks++;
      if (rx_ticks == 8 + 16 * rx_idx) begin
        rx_bits[rx_idx] = tx;
        rx_idx++;
        if (rx_idx == NBITS) begin
          rx_active = 1'b0;
          check_frame();
        end
      end
    end
    prev_tx = tx;

    if (tick_div == TICK_DIV - 1) begin
      tick_div = 0;
      s_tick = tick_en;
    end else begin
      tick_div++;
      s_tick = 1'b0;
    end
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_din = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frame_cnt < target && n < FRAME_BUDGET * 4) begin
      step();
      n++;
    end
    tests_run++;
    if (frame_cnt < target) begin
      tests_failed++;
      $display("FAIL %s_timeout: got %0d frames, want %0d", name, frame_cnt, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (tx_busy !== 1'b0 && n < FRAME_BUDGET);
    tests_run++;
    if (tx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle_timeout: got busy=%b, want 0", name, tx_busy);
    end
  endtask

  task automatic wait_fall(input int nf, input string name);
    int n = 0;
    while (fall_q.size() <= nf && n < FRAME_BUDGET) begin
      step();
      n++;
    end
    tests_run++;
    if (fall_q.size() <= nf) begin
      tests_failed++;
      $display("FAIL %s_fall_timeout: got %0d falls, want >%0d", name, fall_q.size(), nf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) step();
    tests_run++;
    if ({tx, tx_busy, tx_fifo_rd} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_outputs: got tx/busy/rd=%b, want 100", {tx, tx_busy, tx_fifo_rd});
    end
    reset = 1'b0;
    tx_low_seen = 1'b0;
    busy_seen = 1'b0;
    pop_cnt = 0;
    repeat (2500) step();
    tests_run++;
    if (pop_cnt != 0) begin
      tests_failed++;
      $display("FAIL idle_pop: got %0d pops, want 0", pop_cnt);
    end
    tests_run++;
    if (tx_low_seen || busy_seen) begin
      tests_failed++;
      $display("FAIL idle_line: got tx_low=%b busy=%b, want 0 0", tx_low_seen, busy_seen);
    end
  endtask

  task automatic test_single();
    int p0 = pop_cnt;
    int f0 = frame_cnt;
    fifo_q.push_back(8'hA5);
    wait_frames(f0 + 1, "single");
    wait_idle("single");
    tests_run++;
    if (pop_cnt - p0 != 1 || last_rx_byte !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_byte: got pops=%0d byte=%h, want 1 a5", pop_cnt - p0, last_rx_byte);
    end
    tests_run++;
    if (last_busy_len != BUSY_CLKS || tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy_len: got %0d clks tx=%b, want %0d 1", last_busy_len, tx, BUSY_CLKS);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pop_cnt;
    int f0 = frame_cnt;
    int nf = fall_q.size();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    wait_frames(f0 + 3, "b2b");
    wait_idle("b2b");
    tests_run++;
    if (pop_cnt - p0 != 3) begin
      tests_failed++;
      $display("FAIL b2b_pops: got %0d, want 3", pop_cnt - p0);
    end
    tests_run++;
    if (fall_q.size() < nf + 3) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %0d frames started, want 3", fall_q.size() - nf);
    end else if (fall_q[nf+1] - fall_q[nf] != GAP_CLKS || fall_q[nf+2] - fall_q[nf+1] != GAP_CLKS) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %0d and %0d clks, want %0d", fall_q[nf+1] - fall_q[nf],
               fall_q[nf+2] - fall_q[nf+1], GAP_CLKS);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nf = fall_q.size();
    int p1;
    int f0;
    fifo_q.push_back(8'hA5);
    wait_fall(nf, "abort");
    repeat (1000) step();
    p1 = pop_cnt;
    reset = 1'b1;
    rx_active = 1'b0;
    step();
    tests_run++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_fifo_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got tx=%b busy=%b rd=%b, want 1 0 0", tx, tx_busy, tx_fifo_rd);
    end
    exp_q.delete();
    fifo_q.push_back(8'h5A);
    repeat (100) step();
    tests_run++;
    if (pop_cnt != p1) begin
      tests_failed++;
      $display("FAIL abort_no_pop: got %0d pops in reset, want 0", pop_cnt - p1);
    end
    reset = 1'b0;
    f0 = frame_cnt;
    wait_frames(f0 + 1, "after_abort");
    wait_idle("after_abort");
    tests_run++;
    if (last_rx_byte !== 8'h5A) begin
      tests_failed++;
      $display("FAIL after_abort_byte: got %h, want 5a", last_rx_byte);
    end
  endtask

  task automatic test_fifo_during_stop();
    int f0 = frame_cnt;
    int nf = fall_q.size();
    int p0 = pop_cnt;
    fifo_q.push_back(8'h11);
    wait_frames(f0 + 1, "late");
    // Receiver finishes mid stop bit: the transmitter is still in STOP.
    fifo_q.push_back(8'h22);
    step();
    tests_run++;
    if (pop_cnt - p0 != 1) begin
      tests_failed++;
      $display("FAIL late_no_early_pop: got %0d pops, want 1", pop_cnt - p0);
    end
    wait_frames(f0 + 2, "late2");
    wait_idle("late");
    tests_run++;
    if (fall_q.size() < nf + 2 || fall_q[nf+1] - fall_q[nf] != GAP_CLKS) begin
      tests_failed++;
      $display("FAIL late_gap: got %0d falls, want gap %0d", fall_q.size() - nf, GAP_CLKS);
    end
  endtask

  task automatic test_stuck_tick();
    int nf = fall_q.size();
    int f0 = frame_cnt;
    logic tx_hold;
    bit held_bad = 1'b0;
    fifo_q.push_back(8'hC3);
    wait_fall(nf, "stuck");
    repeat (600) step();
    tick_en = 1'b0;
    repeat (TICK_DIV) step();
    tx_hold = tx;
    repeat (3000) begin
      step();
      if (tx !== tx_hold || tx_busy !== 1'b1) held_bad = 1'b1;
    end
    tests_run++;
    if (held_bad || frame_cnt != f0) begin
      tests_failed++;
      $display("FAIL stuck_hold: got changed=%b frames=%0d, want 0 %0d", held_bad, frame_cnt, f0);
    end
    tick_en = 1'b1;
    wait_frames(f0 + 1, "stuck");
    wait_idle("stuck");
    tests_run++;
    if (last_rx_byte !== 8'hC3) begin
      tests_failed++;
      $display("FAIL stuck_byte: got %h, want c3", last_rx_byte);
    end
  endtask

  task automatic test_parity();
    int f0 = frame_cnt;
    fifo_q.push_back(8'h07);
    wait_frames(f0 + 1, "parity");
    wait_idle("parity");
    tests_run++;
    if (last_busy_len != BUSY_CLKS) begin
      tests_failed++;
      $display("FAIL parity_frame_len: got %0d clks, want %0d", last_busy_len, BUSY_CLKS);
    end
`ifdef UART_TX_PARITY_EN
    tests_run++;
    if (last_rx_par !== (PARITY_ODD == 0)) begin
      tests_failed++;
      $display("FAIL parity_bit: got %b, want %b", last_rx_par, PARITY_ODD == 0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_fifo_during_stop();
    test_stuck_tick();
    test_parity();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d bytes left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
